// File: rtl/imem_port_arbiter_pkg.sv
// Shared definitions for the instruction-RAM port arbiter:
// arbiter states, default index width and word-index extraction.
package imem_port_arbiter_pkg;

    localparam int IMEM_IDX_W = 8;

    typedef enum logic {
        RUN  = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    // Byte address to word index; callers truncate to their index width.
    function automatic logic [31:0] word_of(input logic [31:0] adr);
        return adr >> 2;
    endfunction

endpackage

// File: rtl/imem_port_arbiter_if.sv
// Fetch port, loader port and RAM port of the instruction-RAM arbiter.
// slave = arbiter view, master = requesters plus RAM.
interface imem_port_arbiter_if
    import imem_port_arbiter_pkg::*;
#(
    parameter int IDX_W = IMEM_IDX_W
);
    logic             f_req;
    logic [31:0]      f_adr;
    logic             f_gnt;
    logic             f_rvalid;
    logic [31:0]      f_rdata;
    logic             l_req;
    logic             l_we;
    logic [31:0]      l_adr;
    logic [31:0]      l_wdata;
    logic             l_lock;
    logic             l_gnt;
    logic             l_rvalid;
    logic [31:0]      l_rdata;
    logic             locked;
    logic             mem_en;
    logic             mem_we;
    logic [IDX_W-1:0] mem_idx;
    logic [31:0]      mem_wdata;
    logic [31:0]      mem_rdata;

    modport slave (
        input  f_req, f_adr,
        input  l_req, l_we, l_adr, l_wdata, l_lock,
        input  mem_rdata,
        output f_gnt, f_rvalid, f_rdata,
        output l_gnt, l_rvalid, l_rdata,
        output locked,
        output mem_en, mem_we, mem_idx, mem_wdata
    );

    modport master (
        output f_req, f_adr,
        output l_req, l_we, l_adr, l_wdata, l_lock,
        output mem_rdata,
        input  f_gnt, f_rvalid, f_rdata,
        input  l_gnt, l_rvalid, l_rdata,
        input  locked,
        input  mem_en, mem_we, mem_idx, mem_wdata
    );

endinterface

// File: rtl/imem_port_arbiter_age_counter.sv
// Saturating wait counter: counts loader cycles lost to fetch,
// hit flags that the loader has waited long enough to win.
module imem_port_arbiter_age_counter #(
    parameter  int MAX_WAIT = 4,
    localparam int CW       = $clog2(MAX_WAIT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic hit
);

    logic [CW-1:0] cnt;

    assign hit = (cnt == CW'(MAX_WAIT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !hit) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/imem_port_arbiter.sv
// Instruction-RAM arbiter: fetch has priority, loader ages to a win
// after MAX_WAIT lost cycles and can lock the RAM for itself.
module imem_port_arbiter
    import imem_port_arbiter_pkg::*;
#(
    parameter int IDX_W    = IMEM_IDX_W,
    parameter int MAX_WAIT = 4
) (
    input logic                clk,
    input logic                rst,
    imem_port_arbiter_if.slave bus
);

    arb_state_e state;
    arb_state_e state_nx;
    logic       f_gnt;
    logic       l_gnt;
    logic       hit;
    logic       f_rvalid;
    logic       l_rvalid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nx;
        end
    end

    // A lock request only changes ownership from the next cycle on.
    always_comb begin
        state_nx = bus.l_lock ? LOCK : RUN;
        f_gnt    = 1'b0;
        l_gnt    = 1'b0;
        case (state)
            RUN: begin
                if (bus.l_req && hit) begin
                    l_gnt = 1'b1;
                end else if (bus.f_req) begin
                    f_gnt = 1'b1;
                end else if (bus.l_req) begin
                    l_gnt = 1'b1;
                end
            end
            LOCK: begin
                l_gnt = bus.l_req;
            end
            default: begin
                state_nx = RUN;
            end
        endcase
    end

    imem_port_arbiter_age_counter #(
        .MAX_WAIT(MAX_WAIT)
    ) u_age (
        .clk(clk),
        .rst(rst),
        .inc(bus.l_req && !l_gnt),
        .clr(!bus.l_req || l_gnt || state == LOCK),
        .hit(hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_rvalid <= 1'b0;
            l_rvalid <= 1'b0;
        end else begin
            f_rvalid <= f_gnt;
            l_rvalid <= l_gnt && !bus.l_we;
        end
    end

    assign bus.f_gnt     = f_gnt;
    assign bus.l_gnt     = l_gnt;
    assign bus.f_rvalid  = f_rvalid;
    assign bus.l_rvalid  = l_rvalid;
    assign bus.f_rdata   = bus.mem_rdata;
    assign bus.l_rdata   = bus.mem_rdata;
    assign bus.locked    = (state == LOCK);
    assign bus.mem_en    = f_gnt || l_gnt;
    assign bus.mem_we    = l_gnt && bus.l_we;
    assign bus.mem_wdata = l_gnt ? bus.l_wdata : '0;
    assign bus.mem_idx   = l_gnt ? IDX_W'(word_of(bus.l_adr))
                         : f_gnt ? IDX_W'(word_of(bus.f_adr))
                         : '0;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: directed vector table, random traffic
// against a rule-level model, and async reset corner cases.
module tb_imem_port_arbiter;

    localparam int MAX_WAIT = 4;
    localparam int DEPTH    = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    imem_port_arbiter_if #(.IDX_W(8)) bus ();

    imem_port_arbiter #(
        .IDX_W(8),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // RAM stores data xor a per-word pattern so unwritten words differ.
    bit [31:0] ram [DEPTH];

    function automatic logic [31:0] pat(input int i);
        return 32'hA500_0000 | 32'(i);
    endfunction

    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) begin
                ram[bus.mem_idx] <= bus.mem_wdata ^ pat(int'(bus.mem_idx));
            end else begin
                bus.mem_rdata <= ram[bus.mem_idx] ^ pat(int'(bus.mem_idx));
            end
        end
    end

    typedef struct {
        bit          f_req;
        logic [31:0] f_adr;
        bit          l_req;
        bit          l_we;
        logic [31:0] l_adr;
        logic [31:0] l_wdata;
        bit          l_lock;
        bit          x_fgnt;
        bit          x_lgnt;
        logic [7:0]  x_idx;
        bit          x_locked;
    } vec_t;

    vec_t tbl [20];

    logic [31:0] ref_mem [DEPTH];
    bit          m_lock;
    int          m_age;
    bit          e_fg, e_lg, e_fv, e_lv;
    int          e_idx;
    logic [31:0] e_data;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h want %h", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_lock = 1'b0;
        m_age  = 0;
        e_fv   = 1'b0;
        e_lv   = 1'b0;
    endtask

    task automatic model_comb();
        e_lg  = bus.l_req
             && (m_lock || m_age >= MAX_WAIT || !bus.f_req);
        e_fg  = !m_lock && bus.f_req && !e_lg;
        e_idx = e_lg ? int'((bus.l_adr / 4) % DEPTH)
              : e_fg ? int'((bus.f_adr / 4) % DEPTH) : 0;
    endtask

    task automatic model_edge();
        e_fv = e_fg;
        e_lv = e_lg && !bus.l_we;
        if (e_lg && bus.l_we) ref_mem[e_idx] = bus.l_wdata;
        if (e_fv || e_lv) e_data = ref_mem[e_idx];
        if (m_lock || !bus.l_req || e_lg) m_age = 0;
        else if (m_age < MAX_WAIT) m_age = m_age + 1;
        m_lock = bus.l_lock;
    endtask

    task automatic tick(input int row);
        @(negedge clk);
        model_comb();
        if (row >= 0) begin
            chk($sformatf("row%0d f_gnt", row), 32'(bus.f_gnt),
                32'(tbl[row].x_fgnt));
            chk($sformatf("row%0d l_gnt", row), 32'(bus.l_gnt),
                32'(tbl[row].x_lgnt));
            chk($sformatf("row%0d mem_idx", row), 32'(bus.mem_idx),
                32'(tbl[row].x_idx));
            chk($sformatf("row%0d locked", row), 32'(bus.locked),
                32'(tbl[row].x_locked));
        end
        chk("f_gnt", 32'(bus.f_gnt), 32'(e_fg));
        chk("l_gnt", 32'(bus.l_gnt), 32'(e_lg));
        chk("locked", 32'(bus.locked), 32'(m_lock));
        chk("mem_en", 32'(bus.mem_en), 32'(e_fg | e_lg));
        chk("mem_we", 32'(bus.mem_we), 32'(e_lg & bus.l_we));
        if (e_fg || e_lg) chk("mem_idx", 32'(bus.mem_idx), 32'(e_idx));
        if (e_lg && bus.l_we) chk("mem_wdata", bus.mem_wdata, bus.l_wdata);
        @(posedge clk);
        model_edge();
        #1;
        chk("f_rvalid", 32'(bus.f_rvalid), 32'(e_fv));
        chk("l_rvalid", 32'(bus.l_rvalid), 32'(e_lv));
        if (e_fv) chk("f_rdata", bus.f_rdata, e_data);
        if (e_lv) chk("l_rdata", bus.l_rdata, e_data);
    endtask

    task automatic drive(input vec_t v);
        bus.f_req   = v.f_req;
        bus.f_adr   = v.f_adr;
        bus.l_req   = v.l_req;
        bus.l_we    = v.l_we;
        bus.l_adr   = v.l_adr;
        bus.l_wdata = v.l_wdata;
        bus.l_lock  = v.l_lock;
    endtask

    function automatic vec_t mk(
        bit fr, logic [31:0] fa, bit lr, bit lw, logic [31:0] la,
        logic [31:0] ld, bit lk, bit xf, bit xl, logic [7:0] xi, bit xk);
        vec_t v;
        v.f_req = fr; v.f_adr = fa; v.l_req = lr; v.l_we = lw;
        v.l_adr = la; v.l_wdata = ld; v.l_lock = lk;
        v.x_fgnt = xf; v.x_lgnt = xl; v.x_idx = xi; v.x_locked = xk;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = pat(i);
        // fetch streaming and index wrap
        tbl[0]  = mk(1, 32'h000, 0, 0, 0, 0, 0, 1, 0, 8'h00, 0);
        tbl[1]  = mk(1, 32'h004, 0, 0, 0, 0, 0, 1, 0, 8'h01, 0);
        tbl[2]  = mk(1, 32'h008, 0, 0, 0, 0, 0, 1, 0, 8'h02, 0);
        tbl[3]  = mk(1, 32'h400, 0, 0, 0, 0, 0, 1, 0, 8'h00, 0);
        tbl[4]  = mk(1, 32'h7FC, 0, 0, 0, 0, 0, 1, 0, 8'hFF, 0);
        // loader ages past a busy fetch port
        tbl[5]  = mk(1, 32'h00C, 1, 0, 32'h10, 0, 0, 1, 0, 8'h03, 0);
        tbl[6]  = mk(1, 32'h00C, 1, 0, 32'h10, 0, 0, 1, 0, 8'h03, 0);
        tbl[7]  = mk(1, 32'h00C, 1, 0, 32'h10, 0, 0, 1, 0, 8'h03, 0);
        tbl[8]  = mk(1, 32'h00C, 1, 0, 32'h10, 0, 0, 1, 0, 8'h03, 0);
        tbl[9]  = mk(1, 32'h00C, 1, 0, 32'h10, 0, 0, 0, 1, 8'h04, 0);
        tbl[10] = mk(1, 32'h00C, 0, 0, 32'h10, 0, 0, 1, 0, 8'h03, 0);
        // idle fetch: loader write then read-back, low bits ignored
        tbl[11] = mk(0, 0, 1, 1, 32'h7FD, 32'h1234_5678, 0,
                     0, 1, 8'hFF, 0);
        tbl[12] = mk(0, 0, 1, 0, 32'h3FC, 0, 0, 0, 1, 8'hFF, 0);
        tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0);
        // lock rises with a fetch grant, then exclusive loader access
        tbl[14] = mk(1, 32'h020, 0, 0, 0, 0, 1, 1, 0, 8'h08, 0);
        tbl[15] = mk(1, 32'h020, 1, 1, 32'h0C, 32'hDEAD_BEEF, 1,
                     0, 1, 8'h03, 1);
        tbl[16] = mk(1, 32'h020, 1, 0, 32'h0C, 0, 1, 0, 1, 8'h03, 1);
        tbl[17] = mk(1, 32'h020, 0, 0, 0, 0, 1, 0, 0, 8'h00, 1);
        tbl[18] = mk(1, 32'h020, 0, 0, 0, 0, 0, 0, 0, 8'h00, 1);
        tbl[19] = mk(1, 32'h020, 0, 0, 0, 0, 0, 1, 0, 8'h08, 0);

        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        chk("rst f_rvalid", 32'(bus.f_rvalid), 0);
        chk("rst l_rvalid", 32'(bus.l_rvalid), 0);
        chk("rst locked", 32'(bus.locked), 0);
        chk("rst f_gnt", 32'(bus.f_gnt), 0);
        chk("rst l_gnt", 32'(bus.l_gnt), 0);
        chk("rst mem_en", 32'(bus.mem_en), 0);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            drive(tbl[i]);
            tick(i);
        end

        for (int i = 0; i < 400; i++) begin
            bus.f_req   = ($urandom_range(0, 3) != 0);
            bus.f_adr   = $urandom;
            bus.l_req   = ($urandom_range(0, 1) == 1);
            bus.l_we    = ($urandom_range(0, 1) == 1);
            bus.l_adr   = $urandom;
            bus.l_wdata = $urandom;
            if ($urandom_range(0, 15) == 0) bus.l_lock = ~bus.l_lock;
            tick(-1);
        end

        // async reset while locked drops the lock without a clock edge
        drive(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        tick(-1);
        chk("lock before rst", 32'(bus.locked), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async rst locked", 32'(bus.locked), 0);
        bus.l_lock = 1'b0;
        rst = 1'b0;
        model_reset();

        // reset after a fetch grant: no rvalid, aging restarts
        drive(mk(1, 32'h44, 1, 0, 32'h48, 0, 0, 0, 0, 0, 0));
        tick(-1);
        tick(-1);
        @(negedge clk);
        chk("pre-rst f_gnt", 32'(bus.f_gnt), 1);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst mid f_rvalid", 32'(bus.f_rvalid), 0);
        chk("rst mid l_rvalid", 32'(bus.l_rvalid), 0);
        chk("rst mid locked", 32'(bus.locked), 0);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 6; i++) tick(-1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
